// File: rtl/quad_encoder_gen.sv
// quad_encoder_gen: step requests in, A/B quadrature Gray-code out.
// Ports: clk, rst_n (async, active-low), step_valid/step_dir/step_ready
// handshake, enc_a/enc_b registered phases, busy = ~step_ready,
// position = signed net step count (wraps modulo 2^POS_W).
// Optional build macro QENC_BOUNCE_EN adds an LFSR-driven contact
// bounce window of BOUNCE_LEN clocks on the changing line after each edge.
module quad_encoder_gen #(
    parameter int STEP_DIV   = 4096,
    parameter int BOUNCE_LEN = 512,
    parameter int POS_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             step_valid,
    input  logic             step_dir,
    output logic             step_ready,
    output logic             enc_a,
    output logic             enc_b,
    output logic             busy,
    output logic [POS_W-1:0] position
);

    localparam int CNT_W = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STEP_DIV - 2);

    if (STEP_DIV < 2) begin : g_bad_div
        $error("STEP_DIV must be >= 2");
    end
    if (BOUNCE_LEN < 1 || BOUNCE_LEN >= STEP_DIV) begin : g_bad_bounce
        $error("BOUNCE_LEN must be in [1, STEP_DIV)");
    end

    typedef enum logic {
        IDLE,
        SETTLE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;
    logic [1:0]       ph_q, ph_d;
    logic [POS_W-1:0] pos_q;
    logic [1:0]       enc_q;

    // Phase index 0..3 maps to {a,b} = 00,10,11,01 (CW order).
    function automatic logic [1:0] gray(input logic [1:0] p);
        return {p[1] ^ p[0], p[1]};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (step_valid) begin
                    accept  = 1'b1;
                    state_d = SETTLE;
                    cnt_d   = CNT_LOAD;
                end
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reversal simply walks the index the other way.
    assign ph_d = step_dir ? ph_q + 2'd1 : ph_q - 2'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph_q  <= '0;
            pos_q <= '0;
        end else if (accept) begin
            ph_q  <= ph_d;
            pos_q <= pos_q + (step_dir ? POS_W'(1) : {POS_W{1'b1}});
        end
    end

`ifdef QENC_BOUNCE_EN
    localparam int BCNT_W = $clog2(BOUNCE_LEN + 1);
    localparam logic [BCNT_W-1:0] BCNT_LOAD = BCNT_W'(BOUNCE_LEN - 1);

    logic [15:0]       lfsr_q;
    logic [BCNT_W-1:0] bcnt_q;
    logic [1:0]        old_q;

    // Fibonacci x^16+x^14+x^13+x^11+1, right-shifting, output bit 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5],
                       lfsr_q[15:1]};
        end
    end

    // Old and new codes differ in one bit only, so muxing the whole
    // pair chatters the changing line and leaves the other one steady.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enc_q  <= '0;
            old_q  <= '0;
            bcnt_q <= '0;
        end else if (accept) begin
            enc_q  <= gray(ph_d);
            old_q  <= gray(ph_q);
            bcnt_q <= BCNT_LOAD;
        end else if (bcnt_q != '0) begin
            enc_q  <= lfsr_q[0] ? gray(ph_q) : old_q;
            bcnt_q <= bcnt_q - 1'b1;
        end else begin
            enc_q <= gray(ph_q);
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enc_q <= '0;
        end else if (accept) begin
            enc_q <= gray(ph_d);
        end
    end
`endif

    assign enc_a      = enc_q[1];
    assign enc_b      = enc_q[0];
    assign step_ready = (state_q == IDLE);
    assign busy       = ~step_ready;
    assign position   = pos_q;

endmodule

// File: tb/tb_quad_encoder_gen.sv
// tb_quad_encoder_gen: directed + random steps against a phase-table model.
// Two DUTs share stimulus: 16-bit and 4-bit position (wrap coverage).
module tb_quad_encoder_gen;

    localparam int SD = 8;
    localparam int BL = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        step_valid = 1'b0;
    logic        step_dir = 1'b0;
    logic        step_ready, enc_a, enc_b, busy;
    logic [15:0] position;
    logic        step_ready4, enc_a4, enc_b4, busy4;
    logic [3:0]  position4;

    quad_encoder_gen #(.STEP_DIV(SD), .BOUNCE_LEN(BL), .POS_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .step_valid(step_valid), .step_dir(step_dir),
        .step_ready(step_ready), .enc_a(enc_a), .enc_b(enc_b),
        .busy(busy), .position(position)
    );

    quad_encoder_gen #(.STEP_DIV(SD), .BOUNCE_LEN(BL), .POS_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .step_valid(step_valid), .step_dir(step_dir),
        .step_ready(step_ready4), .enc_a(enc_a4), .enc_b(enc_b4),
        .busy(busy4), .position(position4)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          last_acc = -1000;
    int          idx = 0;
    int          pos = 0;
    int          accepts = 0;
    logic [1:0]  old_ab = 2'b00;
    logic [15:0] lf = 16'hACE1;

    // CW order of the {a,b} pair.
    function automatic logic [1:0] code(input int i);
        case (i)
            0: return 2'b00;
            1: return 2'b10;
            2: return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        bit         acc;
        bit         pre;
        logic [1:0] exp_ab;
        @(posedge clk);
        cyc++;
        acc = step_valid && ((cyc - last_acc) >= SD);
        pre = lf[0];
        lf  = {lf[0] ^ lf[2] ^ lf[3] ^ lf[5], lf[15:1]};
        if (acc) begin
            old_ab   = code(idx);
            idx      = step_dir ? (idx + 1) % 4 : (idx + 3) % 4;
            pos      = step_dir ? pos + 1 : pos - 1;
            last_acc = cyc;
            accepts++;
        end
        #1;
        exp_ab = code(idx);
`ifdef QENC_BOUNCE_EN
        if ((cyc - last_acc) >= 1 && (cyc - last_acc) <= BL - 1)
            exp_ab = pre ? code(idx) : old_ab;
`endif
        chk("enc", {30'd0, enc_a, enc_b}, {30'd0, exp_ab});
        chk("enc4", {30'd0, enc_a4, enc_b4}, {30'd0, exp_ab});
        chk("ready", {31'd0, step_ready}, {31'd0, (cyc - last_acc) >= SD - 1});
        chk("busy", {31'd0, busy}, {31'd0, (cyc - last_acc) < SD - 1});
        chk("pos", {16'd0, position}, {16'd0, pos[15:0]});
        chk("pos4", {28'd0, position4}, {28'd0, pos[3:0]});
    endtask

    task automatic req(input bit dir);
        int n0;
        int guard;
        n0    = accepts;
        guard = 0;
        step_valid = 1'b1;
        step_dir   = dir;
        while (accepts == n0 && guard < 4 * SD) begin
            tick();
            guard++;
        end
        step_valid = 1'b0;
        chk("accept_wait", {31'd0, accepts != n0}, 32'd1);
    endtask

    // Asserted between edges so the asynchronous clear is what is seen.
    task automatic reset_dut();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_enc", {30'd0, enc_a, enc_b}, 32'd0);
        chk("rst_pos", {16'd0, position}, 32'd0);
        chk("rst_pos4", {28'd0, position4}, 32'd0);
        chk("rst_ready", {31'd0, step_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        idx      = 0;
        pos      = 0;
        last_acc = -1000;
        lf       = 16'hACE1;
    endtask

    initial begin
        #500000;
        $error("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int saved;
        int guard;

        reset_dut();
        repeat (20) tick();

        step_valid = 1'b1;
        step_dir   = 1'b1;
        guard      = 0;
        while (accepts < 4 && guard < 8 * SD) begin
            tick();
            guard++;
        end
        step_valid = 1'b0;
        chk("cw4_accepts", accepts, 32'd4);
        chk("cw4_pos", {16'd0, position}, 32'd4);
        repeat (SD) tick();

        reset_dut();
        req(1'b1);
        req(1'b1);
        req(1'b0);
        req(1'b0);
        req(1'b0);
        chk("rev_pos", {16'd0, position}, 32'h0000FFFF);
        chk("rev_ab", {30'd0, enc_a, enc_b}, 32'b01);

        req(1'b1);
        saved = pos;
        tick();
        tick();
        step_valid = 1'b1;
        step_dir   = 1'b1;
        tick();
        step_valid = 1'b0;
        chk("pulse_pos", {16'd0, position}, {16'd0, saved[15:0]});
        repeat (SD) tick();

        reset_dut();
        req(1'b0);
        chk("wrap_ccw", {16'd0, position}, 32'h0000FFFF);
        chk("wrap_ccw4", {28'd0, position4}, 32'hF);
        repeat (9) req(1'b1);
        chk("wrap_pos", {16'd0, position}, 32'd8);
        chk("wrap_pos4", {28'd0, position4}, 32'h8);

        req(1'b1);
        tick();
        tick();
        reset_dut();
        repeat (3) tick();

        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 3))
                0: repeat ($urandom_range(1, 5)) tick();
                1, 2: req(1'($urandom_range(0, 1)));
                default: begin
                    if ((cyc - last_acc) < SD - 2) begin
                        step_valid = 1'b1;
                        step_dir   = 1'($urandom_range(0, 1));
                        tick();
                        step_valid = 1'b0;
                    end else begin
                        tick();
                    end
                end
            endcase
        end
        repeat (SD) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
